// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
//   Self-test controller for small combinational lab units. On start it walks
//   every input pattern 0..2**IN_W-1 onto the unit. Each pattern is held for
//   SETTLE cycles and then sampled in a single compare cycle. The sequencer
//   counts mismatches against a golden model and records the first failing
//   pattern.
//
// Ports
//   clk         in   1        system clock, rising edge
//   reset       in   1        synchronous, active-high
//   start       in   1        begin a sweep (level, honoured in idle/done only)
//   dut_in      out  IN_W     pattern driven to the unit under test
//   dut_out     in   OUT_W    unit response
//   exp_out     in   OUT_W    golden-model response to dut_in
//   busy        out  1        sweep in progress
//   done        out  1        sweep finished, results held
//   pass        out  1        done with zero mismatches
//   err_count   out  IN_W+1   number of mismatching patterns
//   first_fail  out  IN_W     first mismatching pattern, valid with fail_valid
//   fail_valid  out  1        at least one mismatch seen this sweep

module truth_table_sequencer #(
    parameter int unsigned IN_W   = 3,
    parameter int unsigned OUT_W  = 1,
    parameter int unsigned SETTLE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    input  logic [OUT_W-1:0]  exp_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [IN_W:0]     err_count,
    output logic [IN_W-1:0]   first_fail,
    output logic              fail_valid
);

    localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [IN_W-1:0]   dut_in_q, dut_in_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IN_W:0]     err_count_q, err_count_d;
    logic [IN_W-1:0]   first_fail_q, first_fail_d;
    logic              fail_valid_q, fail_valid_d;

    always_comb begin
        state_d      = state_q;
        dut_in_d     = dut_in_q;
        cnt_d        = cnt_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        fail_valid_d = fail_valid_q;

        unique case (state_q)
            // A new sweep from either resting state wipes all previous results.
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StSettle;
                    dut_in_d     = '0;
                    cnt_d        = '0;
                    err_count_d  = '0;
                    first_fail_d = '0;
                    fail_valid_d = 1'b0;
                end
            end
            StSettle: begin
                if (cnt_q == CntLast) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StCheck: begin
                if (dut_out != exp_out) begin
                    // Cannot overflow: at most 2**IN_W mismatches fit in IN_W+1 bits.
                    err_count_d = err_count_q + (IN_W+1)'(1);
                    if (!fail_valid_q) begin
                        first_fail_d = dut_in_q;
                        fail_valid_d = 1'b1;
                    end
                end
                if (dut_in_q == {IN_W{1'b1}}) begin
                    state_d = StDone;
                end else begin
                    dut_in_d = dut_in_q + IN_W'(1);
                    cnt_d    = '0;
                    state_d  = StSettle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            dut_in_q     <= '0;
            cnt_q        <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
            fail_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dut_in_q     <= dut_in_d;
            cnt_q        <= cnt_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
            fail_valid_q <= fail_valid_d;
        end
    end

    always_comb begin
        dut_in     = dut_in_q;
        busy       = (state_q == StSettle) || (state_q == StCheck);
        done       = (state_q == StDone);
        pass       = (state_q == StDone) && (err_count_q == '0);
        err_count  = err_count_q;
        first_fail = first_fail_q;
        fail_valid = fail_valid_q;
    end

endmodule
